// File: rtl/axa_tile_scheduler_if.sv
// Handshake bundle between axa_tile_scheduler and the tile memories, the
// accumulator and the shared 2x2 multiplier. master = scheduler side.
interface axa_tile_scheduler_if #(
    parameter int IDX_W = 4
);
    logic             input_Start;
    logic [IDX_W-1:0] input_Dim;
    logic             output_Busy;
    logic             output_Done;
    logic [IDX_W-1:0] output_A_Row;
    logic [IDX_W-1:0] output_A_Col;
    logic [IDX_W-1:0] output_B_Row;
    logic [IDX_W-1:0] output_B_Col;
    logic             output_Mult_Stable;
    logic             input_Mult_AB_Ack;
    logic             input_Mult_Stable;
    logic             output_Mult_C_Ack;
    logic             output_Acc_Req;
    logic             output_Acc_First;
    logic             input_Acc_Ack;
    logic             output_C_Write;
    logic [IDX_W-1:0] output_C_Row;
    logic [IDX_W-1:0] output_C_Col;
    logic             output_Error;

    modport master (
        input  input_Start, input_Dim, input_Mult_AB_Ack, input_Mult_Stable, input_Acc_Ack,
        output output_Busy, output_Done, output_A_Row, output_A_Col, output_B_Row, output_B_Col,
        output output_Mult_Stable, output_Mult_C_Ack, output_Acc_Req, output_Acc_First,
        output output_C_Write, output_C_Row, output_C_Col, output_Error
    );

    modport slave (
        output input_Start, input_Dim, input_Mult_AB_Ack, input_Mult_Stable, input_Acc_Ack,
        input  output_Busy, output_Done, output_A_Row, output_A_Col, output_B_Row, output_B_Col,
        input  output_Mult_Stable, output_Mult_C_Ack, output_Acc_Req, output_Acc_First,
        input  output_C_Write, output_C_Row, output_C_Col, output_Error
    );
endinterface

// File: rtl/axa_tile_scheduler.sv
// Block matrix-product sequencer: walks (i,j,k) tiles through one shared 2x2 multiplier
// and an external accumulator. Optional watchdog abort under macro AXA_SCHED_TIMEOUT_EN.
module axa_tile_scheduler #(
    parameter int IDX_W   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                 input_Clk,
    input  logic                 input_Reset,
    axa_tile_scheduler_if.master bus
);
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT_C  = 3'd2,
        ST_ACC     = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};

    state_t           state_r, state_s;
    logic [IDX_W-1:0] dim_r, dim_s;
    logic [IDX_W-1:0] i_r, i_s, j_r, j_s, k_r, k_s;
    logic [IDX_W-1:0] c_row_r, c_row_s, c_col_r, c_col_s;
    logic [IDX_W-1:0] last_idx_s;
    logic             done_r, done_s;
    logic             c_write_r, c_write_s;
    logic             error_r, error_s;
    logic             busy_r, mult_stable_r, c_ack_r, acc_req_r, acc_first_r;
    logic             timeout_s;

`ifdef AXA_SCHED_TIMEOUT_EN
    localparam int              WD_W     = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0] WD_ONE   = {{(WD_W-1){1'b0}}, 1'b1};

    logic [WD_W-1:0] wd_r;

    // Watchdog: cycles spent in the current state, saturating, cleared on any state change
    always_ff @(posedge input_Clk) begin
        if (input_Reset) begin
            wd_r <= {WD_W{1'b0}};
        end else if (state_s != state_r) begin
            wd_r <= {WD_W{1'b0}};
        end else if (wd_r != WD_LIMIT) begin
            wd_r <= wd_r + WD_ONE;
        end else begin
            wd_r <= wd_r;
        end
    end

    assign timeout_s = (state_r inside {ST_ISSUE, ST_WAIT_C, ST_ACC}) && (wd_r == WD_LIMIT);
`else
    // No watchdog in this build: TIMEOUT has no effect and Error never fires
    assign timeout_s = 1'b0 & (TIMEOUT > 0);
`endif

    assign last_idx_s = dim_r - IDX_ONE;

    // Next state, index advance and one-cycle pulse generation
    always_comb begin
        state_s   = state_r;
        dim_s     = dim_r;
        i_s       = i_r;
        j_s       = j_r;
        k_s       = k_r;
        c_row_s   = c_row_r;
        c_col_s   = c_col_r;
        done_s    = 1'b0;
        c_write_s = 1'b0;
        error_s   = 1'b0;
        if (timeout_s) begin
            state_s = ST_IDLE;
            error_s = 1'b1;
            i_s     = IDX_ZERO;
            j_s     = IDX_ZERO;
            k_s     = IDX_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.input_Start) begin
                        if (bus.input_Dim != IDX_ZERO) begin
                            state_s = ST_ISSUE;
                            dim_s   = bus.input_Dim;
                            i_s     = IDX_ZERO;
                            j_s     = IDX_ZERO;
                            k_s     = IDX_ZERO;
                        end else begin
                            done_s = 1'b1;
                        end
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (bus.input_Mult_AB_Ack) begin
                        state_s = ST_WAIT_C;
                    end else begin
                        state_s = ST_ISSUE;
                    end
                end
                ST_WAIT_C: begin
                    if (bus.input_Mult_Stable) begin
                        state_s = ST_ACC;
                    end else begin
                        state_s = ST_WAIT_C;
                    end
                end
                ST_ACC: begin
                    if (bus.input_Acc_Ack) begin
                        state_s = ST_RELEASE;
                    end else begin
                        state_s = ST_ACC;
                    end
                end
                ST_RELEASE: begin
                    // Indices advance only once the multiplier has withdrawn its product
                    if (!bus.input_Mult_Stable) begin
                        state_s = ST_ISSUE;
                        if (k_r == last_idx_s) begin
                            c_write_s = 1'b1;
                            c_row_s   = i_r;
                            c_col_s   = j_r;
                            k_s       = IDX_ZERO;
                            if (j_r == last_idx_s) begin
                                j_s = IDX_ZERO;
                                if (i_r == last_idx_s) begin
                                    i_s     = IDX_ZERO;
                                    done_s  = 1'b1;
                                    state_s = ST_IDLE;
                                end else begin
                                    i_s = i_r + IDX_ONE;
                                end
                            end else begin
                                j_s = j_r + IDX_ONE;
                            end
                        end else begin
                            k_s = k_r + IDX_ONE;
                        end
                    end else begin
                        state_s = ST_RELEASE;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge input_Clk) begin
        if (input_Reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Counters and registered outputs; handshake levels are decoded from the next state
    always_ff @(posedge input_Clk) begin
        if (input_Reset) begin
            dim_r         <= IDX_ZERO;
            i_r           <= IDX_ZERO;
            j_r           <= IDX_ZERO;
            k_r           <= IDX_ZERO;
            c_row_r       <= IDX_ZERO;
            c_col_r       <= IDX_ZERO;
            done_r        <= 1'b0;
            c_write_r     <= 1'b0;
            error_r       <= 1'b0;
            busy_r        <= 1'b0;
            mult_stable_r <= 1'b0;
            c_ack_r       <= 1'b0;
            acc_req_r     <= 1'b0;
            acc_first_r   <= 1'b0;
        end else begin
            dim_r         <= dim_s;
            i_r           <= i_s;
            j_r           <= j_s;
            k_r           <= k_s;
            c_row_r       <= c_row_s;
            c_col_r       <= c_col_s;
            done_r        <= done_s;
            c_write_r     <= c_write_s;
            error_r       <= error_s;
            busy_r        <= (state_s != ST_IDLE);
            mult_stable_r <= (state_s == ST_ISSUE);
            c_ack_r       <= (state_s == ST_RELEASE);
            acc_req_r     <= (state_s == ST_ACC);
            acc_first_r   <= (state_s == ST_ACC) && (k_s == IDX_ZERO);
        end
    end

    assign bus.output_Busy        = busy_r;
    assign bus.output_Done        = done_r;
    assign bus.output_A_Row       = i_r;
    assign bus.output_A_Col       = k_r;
    assign bus.output_B_Row       = k_r;
    assign bus.output_B_Col       = j_r;
    assign bus.output_Mult_Stable = mult_stable_r;
    assign bus.output_Mult_C_Ack  = c_ack_r;
    assign bus.output_Acc_Req     = acc_req_r;
    assign bus.output_Acc_First   = acc_first_r;
    assign bus.output_C_Write     = c_write_r;
    assign bus.output_C_Row       = c_row_r;
    assign bus.output_C_Col       = c_col_r;
    assign bus.output_Error       = error_r;
endmodule
